decode_execute_core: RTL and testbench

- Decode/execute slice of the 5-stage MIPS pipeline: a 32x32 general register file (GRF), a combinational instruction decoder with branch resolution, and a combinational execute ALU, in one block.
- The top-level pipeline owns the D/E and E/M registers, forwarding muxes and stall logic. It drives this block's GRF write port from M/W, decode inputs from F/D, and execute inputs from D/E.

---
 rtl/decode_execute_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_execute_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_core.sv
// Decode/execute slice of a 5-stage MIPS pipeline: register file with write-through,
// instruction decoder with branch/jump resolution, and the execute-stage ALU.
module decode_execute_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] rt_fwd,
  output logic [4:0]  rd_addr0,
  output logic [4:0]  rd_addr1,
  output logic [31:0] rd_data0,
  output logic [31:0] rd_data1,
  output logic [1:0]  rd_stage0,
  output logic [1:0]  rd_stage1,
  output logic [4:0]  wb_addr,
  output logic [1:0]  wb_stage,
  output logic [3:0]  alu_op_d,
  output logic        alu_src0_d,
  output logic        alu_src1_d,
  output logic [4:0]  sa_d,
  output logic [31:0] ext_imm_d,
  output logic        mem_write_d,
  output logic [31:0] next_pc,
  input  logic [31:0] ex_in0,
  input  logic [31:0] ex_in1,
  input  logic [3:0]  ex_alu_op,
  input  logic        ex_alu_src0,
  input  logic        ex_alu_src1,
  input  logic [4:0]  ex_sa,
  input  logic [31:0] ex_ext_imm,
  output logic [31:0] alu_result
);
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [1:0] ST_DEC  = 2'd0;
  localparam logic [1:0] ST_EX   = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;
  localparam logic [1:0] ST_NONE = 2'd3;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Register file: async clear, $0 never written, reads bypass the pending write
  logic [31:0] regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
    end else if (wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    if (rd_addr0 != '0) rd_data0 = (reset && rd_addr0 == wr_addr) ? wr_data : regs[rd_addr0];
    if (rd_addr1 != '0) rd_data1 = (reset && rd_addr1 == wr_addr) ? wr_data : regs[rd_addr1];
  end

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [1:0]  dest_stage;
  logic [31:0] imm_sext, imm_zext, br_target, j_target, seq_pc;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign sa_d      = instr[10:6];
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext  = {16'h0000, instr[15:0]};
  assign br_target = pc + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc[31:28], instr[25:0], 2'b00};
  assign seq_pc    = pc + 32'd4;

  // Decoder; anything unrecognised (including the all-zero word) falls through as a nop
  always_comb begin
    rd_addr0    = '0;
    rd_stage0   = ST_NONE;
    rd_addr1    = '0;
    rd_stage1   = ST_NONE;
    dest        = '0;
    dest_stage  = ST_NONE;
    alu_op_d    = ALU_ADD;
    alu_src0_d  = 1'b0;
    alu_src1_d  = 1'b0;
    ext_imm_d   = imm_sext;
    mem_write_d = 1'b0;
    next_pc     = seq_pc;
    if (instr != '0) begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
              rd_addr1   = rt;
              rd_stage1  = ST_EX;
              dest       = rd;
              dest_stage = ST_EX;
              // funct[2] distinguishes register-amount shifts, which also read rs
              alu_src0_d = !funct[2];
              if (funct[2]) begin
                rd_addr0  = rs;
                rd_stage0 = ST_EX;
              end
              alu_op_d = (funct[1:0] == 2'b00) ? ALU_SLL : (funct[0] ? ALU_SRA : ALU_SRL);
            end
            FN_JR, FN_JALR: begin
              rd_addr0  = rs;
              rd_stage0 = ST_DEC;
              next_pc   = rs_fwd;
              if (funct == FN_JALR) begin
                dest       = rd;
                dest_stage = ST_DEC;
              end
            end
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
              rd_addr0   = rs;
              rd_stage0  = ST_EX;
              rd_addr1   = rt;
              rd_stage1  = ST_EX;
              dest       = rd;
              dest_stage = ST_EX;
              case (funct)
                FN_SUBU: alu_op_d = ALU_SUB;
                FN_AND:  alu_op_d = ALU_AND;
                FN_OR:   alu_op_d = ALU_OR;
                FN_XOR:  alu_op_d = ALU_XOR;
                FN_NOR:  alu_op_d = ALU_NOR;
                FN_SLT:  alu_op_d = ALU_SLT;
                FN_SLTU: alu_op_d = ALU_SLTU;
                default: alu_op_d = ALU_ADD;
              endcase
            end
            default: ;
          endcase
        end
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          rd_addr0   = rs;
          rd_stage0  = ST_EX;
          dest       = rt;
          dest_stage = ST_EX;
          alu_src1_d = 1'b1;
          case (opcode)
            OP_SLTI:  alu_op_d = ALU_SLT;
            OP_SLTIU: alu_op_d = ALU_SLTU;
            OP_ANDI:  alu_op_d = ALU_AND;
            OP_ORI:   alu_op_d = ALU_OR;
            OP_XORI:  alu_op_d = ALU_XOR;
            OP_LUI:   alu_op_d = ALU_LUI;
            default:  alu_op_d = ALU_ADD;
          endcase
          if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI || opcode == OP_LUI)
            ext_imm_d = imm_zext;
        end
        OP_LW: begin
          rd_addr0   = rs;
          rd_stage0  = ST_EX;
          dest       = rt;
          dest_stage = ST_MEM;
          alu_src1_d = 1'b1;
        end
        OP_SW: begin
          rd_addr0    = rs;
          rd_stage0   = ST_EX;
          rd_addr1    = rt;
          rd_stage1   = ST_MEM;
          alu_src1_d  = 1'b1;
          mem_write_d = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          rd_addr0  = rs;
          rd_stage0 = ST_DEC;
          rd_addr1  = rt;
          rd_stage1 = ST_DEC;
          // opcode[0] set means bne: taken on inequality
          if ((rs_fwd == rt_fwd) != opcode[0]) next_pc = br_target;
        end
        OP_J, OP_JAL: begin
          next_pc = j_target;
          if (opcode == OP_JAL) begin
            dest       = 5'd31;
            dest_stage = ST_DEC;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_addr  = dest;
  assign wb_stage = (dest == '0) ? ST_NONE : dest_stage;

  logic [31:0] alu_b;
  logic [4:0]  shamt;

  assign alu_b = ex_alu_src1 ? ex_ext_imm : ex_in1;
  assign shamt = ex_alu_src0 ? ex_sa : ex_in0[4:0];

  always_comb begin
    alu_result = '0;
    case (ex_alu_op)
      ALU_ADD:  alu_result = ex_in0 + alu_b;
      ALU_SUB:  alu_result = ex_in0 - alu_b;
      ALU_AND:  alu_result = ex_in0 & alu_b;
      ALU_OR:   alu_result = ex_in0 | alu_b;
      ALU_XOR:  alu_result = ex_in0 ^ alu_b;
      ALU_NOR:  alu_result = ~(ex_in0 | alu_b);
      ALU_SLT:  alu_result = {31'd0, $signed(ex_in0) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, ex_in0 < alu_b};
      ALU_SLL:  alu_result = alu_b << shamt;
      ALU_SRL:  alu_result = alu_b >> shamt;
      ALU_SRA:  alu_result = 32'($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_decode_execute_core.sv
// Self-checking bench for decode_execute_core: directed cases followed by random
// instructions built from mnemonics, with expectations derived from each mnemonic's meaning.
module tb_decode_execute_core;
  localparam logic [1:0] SD = 2'd0, SE = 2'd1, SM = 2'd2, SN = 2'd3;

  localparam logic [5:0] R_FN [0:7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [5:0] SH_FN [0:2] = '{6'h00, 6'h02, 6'h03};
  localparam logic [5:0] I_OP [0:6] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  localparam logic [3:0] I_ALU [0:6] = '{4'd0, 4'd6, 4'd7, 4'd2, 4'd3, 4'd4, 4'd11};
  localparam logic [5:0] BAD_OP [0:5] = '{6'h01, 6'h06, 6'h07, 6'h10, 6'h20, 6'h3F};
  localparam logic [5:0] BAD_FN [0:5] = '{6'h01, 6'h05, 6'h0C, 6'h20, 6'h22, 6'h3F};

  typedef struct {
    logic [4:0]  ra0, ra1, wa;
    logic [1:0]  st0, st1, ws;
    logic [3:0]  op;
    logic        s0, s1, mw;
    logic [31:0] imm, npc;
    bit          chk_alu, chk_imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, instr, pc, rs_fwd, rt_fwd;
  logic [4:0]  rd_addr0, rd_addr1, wb_addr, sa_d, ex_sa;
  logic [31:0] rd_data0, rd_data1, ext_imm_d, next_pc;
  logic [1:0]  rd_stage0, rd_stage1, wb_stage;
  logic [3:0]  alu_op_d, ex_alu_op;
  logic        alu_src0_d, alu_src1_d, mem_write_d, ex_alu_src0, ex_alu_src1;
  logic [31:0] ex_in0, ex_in1, ex_ext_imm, alu_result;

  logic [31:0] grf [32];
  int n_checks = 0;
  int n_fail = 0;

  decode_execute_core dut (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr(instr), .pc(pc), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_stage0(rd_stage0), .rd_stage1(rd_stage1), .wb_addr(wb_addr), .wb_stage(wb_stage),
    .alu_op_d(alu_op_d), .alu_src0_d(alu_src0_d), .alu_src1_d(alu_src1_d), .sa_d(sa_d),
    .ext_imm_d(ext_imm_d), .mem_write_d(mem_write_d), .next_pc(next_pc),
    .ex_in0(ex_in0), .ex_in1(ex_in1), .ex_alu_op(ex_alu_op), .ex_alu_src0(ex_alu_src0),
    .ex_alu_src1(ex_alu_src1), .ex_sa(ex_sa), .ex_ext_imm(ex_ext_imm), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic grf_clear();
    for (int i = 0; i < 32; i++) grf[i] = 32'h0;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset && wr_addr != 5'd0) grf[wr_addr] = wr_data;
    #1;
  endtask

  function automatic logic [31:0] grf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (reset && a == wr_addr) return wr_data;
    return grf[a];
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return 32'($signed(b) >>> sh);
      4'd11: return b * 32'h0001_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t nop_exp(input logic [31:0] p);
    exp_t e;
    e.ra0 = 5'd0; e.ra1 = 5'd0; e.wa = 5'd0;
    e.st0 = SN; e.st1 = SN; e.ws = SN;
    e.op = 4'd0; e.s0 = 1'b0; e.s1 = 1'b0; e.mw = 1'b0;
    e.imm = 32'h0; e.npc = p + 32'd4;
    e.chk_alu = 1'b0; e.chk_imm = 1'b0;
    return e;
  endfunction

  // Build instruction k from its mnemonic and describe what decoding it must produce
  task automatic gen_instr(input int k, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] ins, output exp_t e);
    logic [4:0]  s, t, d, sh;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] sx;
    int          j;
    s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); sh = 5'($urandom);
    im = 16'($urandom); tg = 26'($urandom);
    sx = {{16{im[15]}}, im};
    e = nop_exp(p);
    ins = 32'h0;
    if (k <= 7) begin
      ins = {6'h00, s, t, d, sh, R_FN[3'(k)]};
      e.ra0 = s; e.st0 = SE; e.ra1 = t; e.st1 = SE;
      e.wa = d; e.ws = (d == 5'd0) ? SN : SE;
      e.op = 4'(k); e.chk_alu = 1'b1;
    end else if (k <= 13) begin
      j = (k - 8) % 3;
      ins = {6'h00, s, t, d, sh, SH_FN[2'(j)] | ((k >= 11) ? 6'h04 : 6'h00)};
      e.ra1 = t; e.st1 = SE;
      if (k >= 11) begin e.ra0 = s; e.st0 = SE; end
      e.s0 = (k < 11);
      e.wa = d; e.ws = (d == 5'd0) ? SN : SE;
      e.op = 4'(8 + j); e.chk_alu = 1'b1;
    end else if (k <= 20) begin
      j = k - 14;
      ins = {I_OP[3'(j)], s, t, im};
      e.ra0 = s; e.st0 = SE;
      e.wa = t; e.ws = (t == 5'd0) ? SN : SE;
      e.s1 = 1'b1; e.op = I_ALU[3'(j)]; e.chk_alu = 1'b1;
      e.imm = (j >= 3) ? {16'h0000, im} : sx; e.chk_imm = 1'b1;
    end else begin
      case (k)
        21: begin
          ins = {6'h23, s, t, im};
          e.ra0 = s; e.st0 = SE; e.wa = t; e.ws = (t == 5'd0) ? SN : SM;
          e.s1 = 1'b1; e.chk_alu = 1'b1; e.imm = sx; e.chk_imm = 1'b1;
        end
        22: begin
          ins = {6'h2B, s, t, im};
          e.ra0 = s; e.st0 = SE; e.ra1 = t; e.st1 = SM; e.mw = 1'b1;
          e.s1 = 1'b1; e.chk_alu = 1'b1; e.imm = sx; e.chk_imm = 1'b1;
        end
        23, 24: begin
          ins = {(k == 23) ? 6'h04 : 6'h05, s, t, im};
          e.ra0 = s; e.st0 = SD; e.ra1 = t; e.st1 = SD;
          if ((a == b) == (k == 23)) e.npc = p + sx * 32'd4;
        end
        25, 26: begin
          ins = {(k == 25) ? 6'h02 : 6'h03, tg};
          e.npc = (p & 32'hF000_0000) | (32'(tg) * 32'd4);
          if (k == 26) begin e.wa = 5'd31; e.ws = SD; end
        end
        27, 28: begin
          ins = {6'h00, s, t, d, sh, (k == 27) ? 6'h08 : 6'h09};
          e.ra0 = s; e.st0 = SD; e.npc = a;
          if (k == 28) begin e.wa = d; e.ws = (d == 5'd0) ? SN : SD; end
        end
        29: ins = {BAD_OP[3'($urandom_range(0, 5))], s, t, im};
        default: ins = {6'h00, s, t, d, sh, BAD_FN[3'($urandom_range(0, 5))]};
      endcase
    end
    if (ins == 32'h0) e = nop_exp(p);
  endtask

  task automatic check_decode(input exp_t e);
    chk("rd_addr0", 32'(rd_addr0), 32'(e.ra0));
    chk("rd_addr1", 32'(rd_addr1), 32'(e.ra1));
    chk("rd_stage0", 32'(rd_stage0), 32'(e.st0));
    chk("rd_stage1", 32'(rd_stage1), 32'(e.st1));
    chk("rd_data0", rd_data0, grf_read(e.ra0));
    chk("rd_data1", rd_data1, grf_read(e.ra1));
    chk("wb_addr", 32'(wb_addr), 32'(e.wa));
    chk("wb_stage", 32'(wb_stage), 32'(e.ws));
    chk("mem_write_d", 32'(mem_write_d), 32'(e.mw));
    chk("next_pc", next_pc, e.npc);
    chk("sa_d", 32'(sa_d), (instr >> 6) & 32'h1F);
    if (e.chk_alu) begin
      chk("alu_op_d", 32'(alu_op_d), 32'(e.op));
      chk("alu_src0_d", 32'(alu_src0_d), 32'(e.s0));
      chk("alu_src1_d", 32'(alu_src1_d), 32'(e.s1));
    end
    if (e.chk_imm) chk("ext_imm_d", ext_imm_d, e.imm);
  endtask

  initial begin
    reset = 1'b1; wr_addr = 5'd0; wr_data = 32'h0; instr = 32'h0; pc = 32'h0;
    rs_fwd = 32'h0; rt_fwd = 32'h0; ex_in0 = 32'h0; ex_in1 = 32'h0; ex_alu_op = 4'd0;
    ex_alu_src0 = 1'b0; ex_alu_src1 = 1'b0; ex_sa = 5'd0; ex_ext_imm = 32'h0;
    grf_clear();
    #1 reset = 1'b0;
    #2;
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_mem_write", 32'(mem_write_d), 32'd0);
    chk("rst_next_pc", next_pc, 32'd4);
    chk("rst_rd_stage0", 32'(rd_stage0), 32'(SN));
    @(negedge clk);
    reset = 1'b1;

    // $5 written, read through rs, then wiped by an asynchronous reset pulse
    instr = {6'h00, 5'd5, 5'd6, 5'd1, 5'd0, 6'h21};
    wr_addr = 5'd5; wr_data = 32'hAAAA_5555;
    clock_edge();
    wr_addr = 5'd0; wr_data = 32'h0;
    #1 chk("r5_written", rd_data0, 32'hAAAA_5555);
    reset = 1'b0;
    grf_clear();
    #1 chk("r5_async_reset", rd_data0, 32'h0);
    reset = 1'b1;
    #1 chk("r5_after_reset", rd_data0, 32'h0);
    clock_edge();

    instr = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h21};
    wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    #1 chk("r0_same_cycle", rd_data0, 32'h0);
    clock_edge();
    #1 chk("r0_after_edge", rd_data1, 32'h0);
    clock_edge();

    instr = {6'h00, 5'd3, 5'd3, 5'd1, 5'd0, 6'h21};
    wr_addr = 5'd3; wr_data = 32'h1234_5678;
    #1 chk("wt_same_cycle", rd_data0, 32'h1234_5678);
    clock_edge();
    wr_addr = 5'd0; wr_data = 32'h0;
    #1 chk("wt_persist", rd_data1, 32'h1234_5678);
    clock_edge();

    instr = {6'h0D, 5'd2, 5'd1, 16'h8000};
    ex_in0 = 32'h0001_0000; ex_alu_op = 4'd3; ex_alu_src1 = 1'b1; ex_ext_imm = 32'h0000_8000;
    #1;
    chk("ori_ext_imm", ext_imm_d, 32'h0000_8000);
    chk("ori_alu_op", 32'(alu_op_d), 32'd3);
    chk("ori_wb_addr", 32'(wb_addr), 32'd1);
    chk("ori_wb_stage", 32'(wb_stage), 32'(SE));
    chk("ori_rd_stage1", 32'(rd_stage1), 32'(SN));
    chk("ori_alu_src1", 32'(alu_src1_d), 32'd1);
    chk("ori_exec", alu_result, 32'h0001_8000);
    clock_edge();

    instr = {6'h04, 5'd1, 5'd2, 16'hFFFF};
    pc = 32'h3008; rs_fwd = 32'd7; rt_fwd = 32'd7;
    #1 chk("beq_taken", next_pc, 32'h3004);
    rt_fwd = 32'd8;
    #1 chk("beq_not_taken", next_pc, 32'h300C);
    clock_edge();

    instr = {6'h03, 26'h0000C00};
    pc = 32'h3004;
    #1;
    chk("jal_target", next_pc, 32'h0000_3000);
    chk("jal_wb_addr", 32'(wb_addr), 32'd31);
    chk("jal_wb_stage", 32'(wb_stage), 32'(SD));
    instr = {6'h2B, 5'd2, 5'd4, 16'h0010};
    #1;
    chk("sw_mem_write", 32'(mem_write_d), 32'd1);
    chk("sw_rd_stage1", 32'(rd_stage1), 32'(SM));
    chk("sw_wb_addr", 32'(wb_addr), 32'd0);
    clock_edge();

    ex_alu_op = 4'd10; ex_alu_src0 = 1'b1; ex_sa = 5'd4; ex_alu_src1 = 1'b0;
    ex_in0 = 32'h0; ex_in1 = 32'h8000_0000;
    #1 chk("sra_imm", alu_result, 32'hF800_0000);
    ex_alu_op = 4'd6; ex_in0 = 32'hFFFF_FFFF; ex_in1 = 32'd1;
    #1 chk("slt_signed", alu_result, 32'd1);
    ex_alu_op = 4'd7;
    #1 chk("sltu_unsigned", alu_result, 32'd0);
    clock_edge();

    for (int it = 0; it < 300; it++) begin
      exp_t        e;
      logic [31:0] ins;
      logic [4:0]  sh;
      logic [31:0] bop;
      pc = $urandom & 32'hFFFF_FFFC;
      rs_fwd = $urandom;
      rt_fwd = ($urandom_range(0, 1) == 1) ? rs_fwd : $urandom;
      gen_instr($urandom_range(0, 30), pc, rs_fwd, rt_fwd, ins, e);
      instr = ins;
      wr_data = $urandom;
      case ($urandom_range(0, 3))
        0: wr_addr = 5'd0;
        1: wr_addr = e.ra0;
        2: wr_addr = e.ra1;
        default: wr_addr = 5'($urandom);
      endcase
      ex_in0 = $urandom; ex_in1 = $urandom; ex_ext_imm = $urandom;
      ex_alu_op = 4'($urandom_range(0, 11));
      ex_alu_src0 = 1'($urandom); ex_alu_src1 = 1'($urandom); ex_sa = 5'($urandom);
      #1;
      check_decode(e);
      bop = ex_alu_src1 ? ex_ext_imm : ex_in1;
      sh = ex_alu_src0 ? ex_sa : ex_in0[4:0];
      chk("alu_result", alu_result, alu_model(ex_alu_op, ex_in0, bop, sh));
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
